// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, deframes 11-bit frames and
// folds E0/F0 prefixes into the 11-bit {toggle, pressed, ext, code} key word.
module ps2_key_encoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic [FW-1:0]          filt_cnt;
  logic                   filt_clk, filt_prev, fall;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        ext_q, ext_d, brk_q, brk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0] key_d;
  logic        strobe_d, err_d;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = filt_prev & ~filt_clk;

  // Idle PS/2 lines are high, so the conditioning chain resets to 1 to avoid a phantom fall.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      filt_prev <= filt_clk;
      if (clk_s != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = ps2_key;
    strobe_d  = 1'b0;
    err_d     = 1'b0;

    if (state_q == S_IDLE || fall) tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;
    else tmo_d = tmo_q;

    if (fall) begin
      unique case (state_q)
        S_IDLE: if (!data_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
        S_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = data_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if ((^{shift_q, par_q}) && data_s) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              key_d    = {~ps2_key[10], ~brk_q, ext_q, shift_q};
              strobe_d = 1'b1;
              ext_d    = 1'b0;
              brk_d    = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      // A stalled frame is abandoned along with any prefixes collected so far.
      err_d   = 1'b1;
      state_d = S_IDLE;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      tmo_q      <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      tmo_q      <= tmo_d;
      ps2_key    <= key_d;
      key_strobe <= strobe_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: table of PS/2 frames with expected key words,
// a scoreboard queue popped by an output monitor, and hand sequences for glitch, timeout and reset.
module tb_ps2_key_encoder;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 6000;
  localparam int HALF           = 20;
  localparam int DRAIN_LIMIT    = 2000;

  typedef enum logic [1:0] {K_NONE, K_KEY, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [10:0] key;
  } exp_t;
  typedef struct {
    logic [7:0] b;
    bit         flip_par;
    bit         stop_v;
    kind_e      kind;
    logic [9:0] lo;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        m_tog = 1'b0;
  logic [10:0] m_key = '0;

  ps2_key_encoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_key(ps2_key),
    .key_strobe(key_strobe),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Frame bits LSB first: start, 8 data, odd parity (optionally corrupted), stop.
  task automatic send_bits(input logic [7:0] b, input bit flip_par, input bit stop_v,
                           input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop_v, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = bits[i];
      cyc(HALF / 2);
      ps2_clk_in = 1'b0;
      cyc(HALF);
      ps2_clk_in = 1'b1;
      if (i == glitch_bit) begin
        cyc(5);
        ps2_clk_in = 1'b0;
        cyc(FILTER_LEN - 2);
        ps2_clk_in = 1'b1;
      end
      cyc(HALF);
    end
    ps2_data_in = 1'b1;
  endtask

  task automatic expect_event(input kind_e kind, input logic [9:0] lo);
    exp_t e;
    if (kind == K_KEY) begin
      m_tog = ~m_tog;
      m_key = {m_tog, lo};
    end
    e.kind = kind;
    e.key  = m_key;
    if (kind != K_NONE) sb.push_back(e);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      cyc(1);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic run_frame(input vec_t v, input int glitch_bit);
    expect_event(v.kind, v.lo);
    send_bits(v.b, v.flip_par, v.stop_v, 11, glitch_bit);
    drain("drain_frame", DRAIN_LIMIT);
    cyc(30);
  endtask

  always @(negedge clk_sys) begin
    if (reset_n && (key_strobe || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {30'd0, key_strobe, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {30'd0, key_strobe, frame_err},
              (e.kind == K_KEY) ? 32'd2 : 32'd1);
        check("ps2_key", {21'd0, ps2_key}, {21'd0, e.key});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vecs = '{
      '{8'h1C, 1'b0, 1'b1, K_KEY,  10'h21C},
      '{8'hE0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'hF0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'h75, 1'b0, 1'b1, K_KEY,  10'h175},
      '{8'h29, 1'b1, 1'b1, K_ERR,  10'h000},
      '{8'h29, 1'b0, 1'b1, K_KEY,  10'h229},
      '{8'hE0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'hE0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'h14, 1'b0, 1'b1, K_KEY,  10'h314},
      '{8'hF0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'hF0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'h5A, 1'b0, 1'b1, K_KEY,  10'h05A},
      '{8'hAA, 1'b0, 1'b1, K_KEY,  10'h2AA},
      '{8'hE1, 1'b0, 1'b1, K_KEY,  10'h2E1},
      '{8'hFA, 1'b0, 1'b1, K_KEY,  10'h2FA},
      '{8'h12, 1'b0, 1'b0, K_ERR,  10'h000},
      '{8'hE0, 1'b0, 1'b1, K_NONE, 10'h000},
      '{8'h33, 1'b1, 1'b1, K_ERR,  10'h000},
      '{8'h6B, 1'b0, 1'b1, K_KEY,  10'h26B},
      '{8'h00, 1'b0, 1'b1, K_KEY,  10'h200},
      '{8'hFF, 1'b0, 1'b1, K_KEY,  10'h2FF}
    };

    cyc(3);
    check("reset_ps2_key", {21'd0, ps2_key}, 32'd0);
    check("reset_key_strobe", {31'd0, key_strobe}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    cyc(20);

    foreach (vecs[i]) run_frame(vecs[i], -1);

    // Sub-filter clock glitch in the middle of a frame must not shift an extra bit.
    run_frame('{8'h16, 1'b0, 1'b1, K_KEY, 10'h216}, 4);

    // Stalled frame: start + 4 data bits, then silence until the timeout fires.
    expect_event(K_ERR, 10'h000);
    send_bits(8'h0F, 1'b0, 1'b1, 5, -1);
    cyc(TIMEOUT_CYCLES - 100);
    check("no_early_timeout", sb.size(), 32'd1);
    drain("timeout_err", 400);
    cyc(30);
    run_frame('{8'h6B, 1'b0, 1'b1, K_KEY, 10'h26B}, -1);

    // Reset after an E0 prefix wipes outputs and the pending prefix.
    run_frame('{8'hE0, 1'b0, 1'b1, K_NONE, 10'h000}, -1);
    reset_n = 1'b0;
    cyc(2);
    check("midreset_ps2_key", {21'd0, ps2_key}, 32'd0);
    check("midreset_key_strobe", {31'd0, key_strobe}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    m_tog = 1'b0;
    m_key = '0;
    reset_n = 1'b1;
    cyc(10);
    run_frame('{8'h75, 1'b0, 1'b1, K_KEY, 10'h275}, -1);
    check("post_reset_key", {21'd0, ps2_key}, 32'h675);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
